serializer_sequencer: RTL and testbench

Round-robin sequencer that shares one 8-bit LSB-first serializer among NUM_REQ byte requesters. It owns the serializer's `start`/`reset`/`data_in` controls and watches its `done_transmit`. For each byte it latches the granted requester's data, clears the serializer, holds it in shift mode until done, then acknowledges the requester. It sits between the NV controller's command sources and the serializer instance that drives the serial data line.

---
 rtl/nv_ser_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/serializer_sequencer.sv | 150 +++++++++++++++
 tb/tb_serializer_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_ser_pkg.sv
// Shared definitions for the NV serializer sequencer and its round-robin arbiter.
package nv_ser_pkg;

  // Sequencer states: wait for a request, clear the serializer, shift, acknowledge.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_RELEASE = 2'd3
  } ser_state_e;

  localparam int SER_BYTE_W          = 8;
  localparam int SER_SHIFT_CYCLES    = 10;  // nominal SHIFT dwell with a healthy serializer
  localparam int SER_TIMEOUT_DEFAULT = 16;

  // Index reached by stepping 'off' places past 'base' on a ring of n entries
  // (base < n, off <= n).
  function automatic int rr_wrap(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? sum - n : sum;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after last_id has the
// highest priority, wrapping around the ring. Reusable for any shared resource.
module rr_arbiter
  import nv_ser_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last_id,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  // Walk from the farthest ring position inwards so the nearest active requester wins.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves one unassigned and no latch appears.
    gnt       = '0;
    gnt_id    = last_id;
    gnt_valid = 1'b0;
    for (int off = N; off >= 1; off--) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && (i == rr_wrap(int'(last_id), off, N))) begin
          gnt       = '0;
          gnt[i]    = 1'b1;
          gnt_id    = ID_W'(i);
          gnt_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/serializer_sequencer.sv
// Round-robin sequencer sharing one LSB-first byte serializer among NUM_REQ
// requesters. Optional SHIFT-state watchdog compiled in with `define SER_TIMEOUT_EN.
module serializer_sequencer
  import nv_ser_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = SER_TIMEOUT_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [SER_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [SER_BYTE_W-1:0]         ser_data,
  output logic                          ser_start,
  output logic                          ser_reset,
  input  logic                          ser_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  ser_state_e            state_q, state_d;
  logic [SER_BYTE_W-1:0] ser_data_q, ser_data_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic                  ser_start_q, ser_start_d;
  logic                  ser_reset_q, ser_reset_d;
  logic                  busy_q, busy_d;
  logic [NUM_REQ-1:0]    req_ack_q, req_ack_d;

  logic [NUM_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]       arb_id;
  logic                  arb_valid;

`ifdef SER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .last_id   (grant_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  // Next state, byte latch and grant bookkeeping (plus watchdog when compiled in).
  always_comb begin
    state_d    = state_q;
    ser_data_d = ser_data_q;
    grant_d    = grant_q;
`ifdef SER_TIMEOUT_EN
    tmo_err_d  = tmo_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) ser_data_d = req_data[i*SER_BYTE_W +: SER_BYTE_W];
          end
          grant_d = arb_id;
          state_d = ST_ARM;
        end
      end
      ST_ARM:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (ser_done) begin
          state_d = ST_RELEASE;
        end
`ifdef SER_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          // Serializer never finished: drop the byte but still release the requester.
          state_d   = ST_RELEASE;
          tmo_err_d = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;  // ST_RELEASE
    endcase
`ifdef SER_TIMEOUT_EN
    // Counts completed SHIFT cycles; cleared whenever SHIFT is left or not yet entered.
    tmo_cnt_d = ((state_q == ST_SHIFT) && (state_d == ST_SHIFT)) ? tmo_cnt_q + 1'b1 : '0;
`endif
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    ser_start_d = (state_d == ST_ARM) || (state_d == ST_SHIFT);
    ser_reset_d = (state_d == ST_ARM);
    busy_d      = (state_d != ST_IDLE);
    req_ack_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ack_d[i] = (state_d == ST_RELEASE) && (grant_d == ID_W'(i));
    end
  end

  // State and registered outputs; grant pointer resets so requester 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ser_data_q  <= '0;
      grant_q     <= ID_W'(NUM_REQ - 1);
      ser_start_q <= 1'b0;
      ser_reset_q <= 1'b0;
      busy_q      <= 1'b0;
      req_ack_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values regardless of statement order.
      state_q     <= state_d;
      ser_data_q  <= ser_data_d;
      grant_q     <= grant_d;
      ser_start_q <= ser_start_d;
      ser_reset_q <= ser_reset_d;
      busy_q      <= busy_d;
      req_ack_q   <= req_ack_d;
    end
  end

`ifdef SER_TIMEOUT_EN
  // Watchdog counter and sticky abort flag; only reset_n clears the flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign ser_data  = ser_data_q;
  assign grant_id  = grant_q;
  assign ser_start = ser_start_q;
  assign ser_reset = ser_reset_q;
  assign busy      = busy_q;
  assign req_ack   = req_ack_q;

endmodule

// File: tb/tb_serializer_sequencer.sv
// Self-checking bench for serializer_sequencer with a behavioural serializer model.
module tb_serializer_sequencer;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic [7:0]     ser_data;
  logic           ser_start;
  logic           ser_reset;
  logic           ser_done = 1'b0;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  int errors = 0;
  int checks = 0;
  int rr_last;
  logic exp_tmo;

  always #5 clk = ~clk;

  serializer_sequencer #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .ser_data    (ser_data),
    .ser_start   (ser_start),
    .ser_reset   (ser_reset),
    .ser_done    (ser_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  // Serializer model: clear on start&reset, shift 8 bits LSB first, done flag on
  // the 8th shift, done output one edge later; frozen while start is low.
  logic [3:0] sm_cnt       = 4'd0;
  logic       sm_done_flag = 1'b0;
  bit         block_done   = 1'b0;
  bit         serial_bits[$];

  always @(posedge clk) begin
    if (ser_start) begin
      if (ser_reset) begin
        sm_cnt       <= 4'd0;
        sm_done_flag <= 1'b0;
        ser_done     <= 1'b0;
      end else begin
        if (sm_cnt < 4'd8) begin
          serial_bits.push_back(ser_data[sm_cnt[2:0]]);
          sm_cnt <= sm_cnt + 4'd1;
          if (sm_cnt == 4'd7) sm_done_flag <= 1'b1;
        end
        ser_done <= sm_done_flag & ~block_done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first active requester after 'last', wrapping; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last + off) % N;
      for (int i = 0; i < N; i++) if (i == idx && v[i]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [7:0] collected_byte();
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < serial_bits.size() && i < 8; i++) b[i] = serial_bits[i];
    return b;
  endfunction

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rr_last = N - 1;
  endtask

  // One full byte, entered at the negedge of an IDLE cycle (k=1). Returns at the
  // negedge of the following IDLE cycle.
  task automatic run_byte(input logic [N-1:0] v, input logic [8*N-1:0] d, input int mid_k,
                          input logic [N-1:0] mid_v, input int exp_k, input string tag);
    int win;
    int k;
    logic [7:0]   exp_byte;
    logic [N-1:0] exp_ack;
    win = pick(v, rr_last);
    exp_byte = 8'h00;
    exp_ack  = '0;
    for (int i = 0; i < N; i++) begin
      if (i == win) begin
        exp_byte   = d[i*8 +: 8];
        exp_ack[i] = 1'b1;
      end
    end
    serial_bits.delete();
    req_valid = v;
    req_data  = d;
    k = 1;
    while (req_ack == '0 && k < exp_k + 10) begin
      @(negedge clk);
      k++;
      if (k == mid_k) begin
        req_valid = mid_v;
        req_data  = $urandom;
      end
    end
    check({tag, "_ack_cycle"}, k, exp_k);
    check({tag, "_ack"}, req_ack, exp_ack);
    check({tag, "_grant"}, grant_id, win);
    check({tag, "_ser_data"}, ser_data, exp_byte);
    check({tag, "_nbits"}, serial_bits.size(), 8);
    check({tag, "_bits"}, collected_byte(), exp_byte);
    check({tag, "_tmo_err"}, timeout_err, exp_tmo);
    rr_last = win;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_ack_pulse"}, req_ack, '0);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic         exp_busy;
    logic         exp_start;
    logic         exp_rst;
    logic [N-1:0] exp_ack;
    logic [7:0]   exp_data;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Cycle-by-cycle expectation for a single 8'h2D byte from requester 0.
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h00};  // IDLE
    tbl[1]  = '{4'b0001, 1'b1, 1'b1, 1'b1, 4'b0000, 8'h2D};  // ARM
    for (int k = 2; k <= 11; k++) tbl[k] = '{4'b0001, 1'b1, 1'b1, 1'b0, 4'b0000, 8'h2D};  // SHIFT
    tbl[12] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b0001, 8'h2D};  // RELEASE
    tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 8'h2D};  // IDLE

    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    exp_tmo   = 1'b0;
    rr_last   = N - 1;

    // Reset values
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_start", ser_start, 1'b0);
    check("rst_ser_reset", ser_reset, 1'b0);
    check("rst_ser_data", ser_data, 8'h00);
    check("rst_ack", req_ack, '0);
    check("rst_grant", grant_id, 2'd3);
    check("rst_tmo", timeout_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single byte, table-driven
    serial_bits.delete();
    req_data = 32'h0000_002D;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      req_valid = tbl[k].valid;
      check($sformatf("tbl%0d_busy", k), busy, tbl[k].exp_busy);
      check($sformatf("tbl%0d_start", k), ser_start, tbl[k].exp_start);
      check($sformatf("tbl%0d_sreset", k), ser_reset, tbl[k].exp_rst);
      check($sformatf("tbl%0d_ack", k), req_ack, tbl[k].exp_ack);
      check($sformatf("tbl%0d_data", k), ser_data, tbl[k].exp_data);
    end
    check("tbl_bits", collected_byte(), 8'h2D);
    check("tbl_nbits", serial_bits.size(), 8);

    // All four requesting: grants 0,1,2,3,0 back-to-back from reset
    apply_reset();
    for (int b = 0; b < 5; b++) run_byte(4'b1111, 32'h4433_2211, 0, '0, 13, $sformatf("all%0d", b));

    // Requesters 1 and 3 only: alternate
    for (int b = 0; b < 4; b++) run_byte(4'b1010, 32'hA5C3_5A3C, 0, '0, 13, $sformatf("odd%0d", b));

    // Requester 2 drops valid during SHIFT; byte still completes, then no re-grant
    run_byte(4'b0100, 32'h00B7_0000, 5, 4'b0000, 13, "drop");
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("drop_idle_busy", busy, 1'b0);
      check("drop_idle_ack", req_ack, '0);
    end
    run_byte(4'b0101, 32'h0099_0066, 0, '0, 13, "after_drop");

    // Asynchronous reset during SHIFT cycle 5
    serial_bits.delete();
    req_valid = 4'b0001;
    req_data  = 32'h0000_002D;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_start", ser_start, 1'b0);
    check("arst_sreset", ser_reset, 1'b0);
    check("arst_data", ser_data, 8'h00);
    check("arst_ack", req_ack, '0);
    check("arst_grant", grant_id, 2'd3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("arst_hold_ack", req_ack, '0);
    end
    reset_n = 1'b1;
    rr_last = N - 1;
    run_byte(4'b0001, 32'h0000_002D, 0, '0, 13, "post_rst");

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] v;
      int mk;
      if ($urandom_range(0, 3) == 0) begin
        req_valid = '0;
        @(negedge clk);
        check("gap_busy", busy, 1'b0);
      end
      v  = N'($urandom_range(1, (1 << N) - 1));
      mk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 12)) : 0;
      run_byte(v, $urandom, mk, N'($urandom), 13, $sformatf("rnd%0d", t));
    end

`ifdef SER_TIMEOUT_EN
    // Serializer never signals done: abort after 16 SHIFT cycles, flag stays set
    block_done = 1'b1;
    exp_tmo    = 1'b1;
    run_byte(4'b0010, 32'h0000_7E00, 0, '0, 19, "tmo");
    block_done = 1'b0;
    run_byte(4'b1000, 32'h5100_0000, 0, '0, 13, "tmo_after1");
    run_byte(4'b0001, 32'h0000_00C4, 0, '0, 13, "tmo_after2");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
